mtr_drv: RTL and testbench



---
 rtl/mtr_pkg.sv | 22 ++
 rtl/mtr_side.sv | 128 ++++++++++++
 rtl/mtr_drv.sv | 59 +++++
 tb/tb_mtr_drv.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor driver.
package mtr_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] PWM_MAX = 11'h7FF;

    typedef enum logic [1:0] {MTR_FWD, MTR_REV, MTR_DEAD} mtr_state_t;

    // Magnitude of a signed 12-bit command; -2048 saturates to PWM_MAX.
    function automatic logic [PWM_W-1:0] spd_mag(input logic [11:0] spd);
        logic [11:0] neg;
        neg = -spd;
        if (!spd[11]) begin
            return spd[PWM_W-1:0];
        end else if (spd == 12'h800) begin
            return PWM_MAX;
        end else begin
            return neg[PWM_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mtr_side.sv
// One H-bridge side: boundary sampler, FWD/REV/DEAD state machine and PWM flops.
// Optional duty slew limiting is enabled by defining MTR_SLEW_LIMIT_EN.
module mtr_side
    import mtr_pkg::*;
#(
    parameter int unsigned DEAD_PERIODS = 1,
    parameter int unsigned SLEW_STEP    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] cnt,
    input  logic             boundary,
    input  logic [11:0]      spd,
    output logic             pwm1,
    output logic             pwm2
);

    if (DEAD_PERIODS < 1 || DEAD_PERIODS > 3) begin : g_bad_dead
        $error("DEAD_PERIODS must be in 1..3");
    end
    if (SLEW_STEP < 1 || SLEW_STEP > 2047) begin : g_bad_slew
        $error("SLEW_STEP must be in 1..2047");
    end

    localparam logic [1:0] DeadInit = 2'(DEAD_PERIODS - 1);
`ifdef MTR_SLEW_LIMIT_EN
    localparam logic [PWM_W-1:0] Step = PWM_W'(SLEW_STEP);
`endif

    mtr_state_t       state_q, state_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [1:0]       dead_q, dead_d;
    logic             prev_rev_q, prev_rev_d;
    logic [PWM_W-1:0] mag;
    logic [PWM_W-1:0] cnt_nxt;
    logic             samp_rev, cur_rev;
    logic             pwm1_d, pwm2_d;

    // Next-state, duty and PWM decisions; only the boundary edge changes state.
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        dead_d     = dead_q;
        prev_rev_d = prev_rev_q;
        mag        = spd_mag(spd);
        samp_rev   = spd[11];
        cur_rev    = (state_q == MTR_REV);
        cnt_nxt    = cnt + 11'd1;
        if (boundary) begin
            unique case (state_q)
                MTR_FWD, MTR_REV: begin
                    if (samp_rev == cur_rev || mag == '0) begin
`ifdef MTR_SLEW_LIMIT_EN
                        if (mag > duty_q) begin
                            duty_d = (mag - duty_q > Step) ? duty_q + Step : mag;
                        end else begin
                            duty_d = (duty_q - mag > Step) ? duty_q - Step : mag;
                        end
`else
                        duty_d = mag;
`endif
                    end else begin
`ifdef MTR_SLEW_LIMIT_EN
                        // Ramp down in the old direction before going dead.
                        if (duty_q > Step) begin
                            duty_d = duty_q - Step;
                        end else begin
                            state_d    = MTR_DEAD;
                            duty_d     = '0;
                            dead_d     = DeadInit;
                            prev_rev_d = cur_rev;
                        end
`else
                        state_d    = MTR_DEAD;
                        duty_d     = '0;
                        dead_d     = DeadInit;
                        prev_rev_d = cur_rev;
`endif
                    end
                end
                MTR_DEAD: begin
                    if (dead_q != 2'd0) begin
                        dead_d = dead_q - 2'd1;
                    end else if (mag == '0) begin
                        // Command dropped to zero while dead: resume old direction idle.
                        state_d = prev_rev_q ? MTR_REV : MTR_FWD;
                        duty_d  = '0;
                    end else begin
                        state_d = samp_rev ? MTR_REV : MTR_FWD;
`ifdef MTR_SLEW_LIMIT_EN
                        duty_d = (mag > Step) ? Step : mag;
`else
                        duty_d = mag;
`endif
                    end
                end
                default: begin
                    state_d = MTR_FWD;
                    duty_d  = '0;
                    dead_d  = 2'd0;
                end
            endcase
        end
        // Use next state/duty so a new period starts with its new settings.
        pwm1_d = (state_d == MTR_FWD) && (cnt_nxt < duty_d);
        pwm2_d = (state_d == MTR_REV) && (cnt_nxt < duty_d);
    end

    // State, duty and registered PWM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MTR_FWD;
            duty_q     <= '0;
            dead_q     <= 2'd0;
            prev_rev_q <= 1'b0;
            pwm1       <= 1'b0;
            pwm2       <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dead_q     <= dead_d;
            prev_rev_q <= prev_rev_d;
            pwm1       <= pwm1_d;
            pwm2       <= pwm2_d;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: shared 2048-cycle counter plus one mtr_side per wheel.
// Define MTR_SLEW_LIMIT_EN to limit duty change per period to SLEW_STEP.
module mtr_drv
    import mtr_pkg::*;
#(
    parameter int unsigned DEAD_PERIODS = 1,
    parameter int unsigned SLEW_STEP    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_spd,
    input  logic [11:0] right_spd,
    output logic        lftPWM1,
    output logic        lftPWM2,
    output logic        rghtPWM1,
    output logic        rghtPWM2,
    output logic        period_tick
);

    logic [PWM_W-1:0] cnt_q;

    // Free-running period counter, wraps 2047 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 11'd1;
        end
    end

    assign period_tick = (cnt_q == PWM_MAX);

    mtr_side #(
        .DEAD_PERIODS (DEAD_PERIODS),
        .SLEW_STEP    (SLEW_STEP)
    ) u_left (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt      (cnt_q),
        .boundary (period_tick),
        .spd      (lft_spd),
        .pwm1     (lftPWM1),
        .pwm2     (lftPWM2)
    );

    mtr_side #(
        .DEAD_PERIODS (DEAD_PERIODS),
        .SLEW_STEP    (SLEW_STEP)
    ) u_right (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt      (cnt_q),
        .boundary (period_tick),
        .spd      (right_spd),
        .pwm1     (rghtPWM1),
        .pwm2     (rghtPWM2)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: vector table, hand sequences and a
// period-level reference model fed by random commands.
module tb_mtr_drv;

    localparam int DEAD = 1;
`ifdef MTR_SLEW_LIMIT_EN
    localparam bit MODEL_EN = 1'b0;
`else
    localparam bit MODEL_EN = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft_spd = '0;
    logic [11:0] right_spd = '0;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_tick;

    always #5 clk = ~clk;

    mtr_drv #(
        .DEAD_PERIODS (DEAD),
        .SLEW_STEP    (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lft_spd     (lft_spd),
        .right_spd   (right_spd),
        .lftPWM1     (lftPWM1),
        .lftPWM2     (lftPWM2),
        .rghtPWM1    (rghtPWM1),
        .rghtPWM2    (rghtPWM2),
        .period_tick (period_tick)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected period position of the DUT.
    logic [10:0] tb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 11'd1;
    end

    // Reference model per side (0 = left, 1 = right): signed direction,
    // duty, and number of dead periods still to run.
    int m_dir[2];
    int m_duty[2];
    int m_dead[2];
    int cnt_hi[2][2];
    int last[2][2];

    function automatic int exp_hi(input int s, input int o);
        if (m_dead[s] != 0) return 0;
        if (o == 0) return (m_dir[s] > 0) ? m_duty[s] : 0;
        return (m_dir[s] < 0) ? m_duty[s] : 0;
    endfunction

    task automatic model_update(input int s, input logic [11:0] cmd);
        int v, m, d;
        v = int'($signed(cmd));
        m = (v < 0) ? -v : v;
        if (m > 2047) m = 2047;
        d = (v < 0) ? -1 : 1;
        if (m_dead[s] > 0) begin
            m_dead[s]--;
            if (m_dead[s] == 0) begin
                if (m != 0) begin
                    m_dir[s]  = d;
                    m_duty[s] = m;
                end else begin
                    m_duty[s] = 0;
                end
            end
        end else if (m == 0 || d == m_dir[s]) begin
            m_duty[s] = m;
        end else begin
            m_dead[s] = DEAD;
            m_duty[s] = 0;
        end
    endtask

    // Per-cycle checks plus per-period duty comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                m_dir[s]  = 1;
                m_duty[s] = 0;
                m_dead[s] = 0;
                cnt_hi[s][0] = 0;
                cnt_hi[s][1] = 0;
            end
        end else begin
            chk("overlap_left", int'(lftPWM1 & lftPWM2), 0);
            chk("overlap_right", int'(rghtPWM1 & rghtPWM2), 0);
            chk("period_tick", int'(period_tick), int'(tb_cnt == 11'h7FF));
            cnt_hi[0][0] += int'(lftPWM1);
            cnt_hi[0][1] += int'(lftPWM2);
            cnt_hi[1][0] += int'(rghtPWM1);
            cnt_hi[1][1] += int'(rghtPWM2);
            if (tb_cnt == 11'h7FF) begin
                for (int s = 0; s < 2; s++) begin
                    for (int o = 0; o < 2; o++) begin
                        last[s][o] = cnt_hi[s][o];
                        if (MODEL_EN) begin
                            chk($sformatf("model_side%0d_pwm%0d", s, o + 1),
                                cnt_hi[s][o], exp_hi(s, o));
                        end
                        cnt_hi[s][o] = 0;
                    end
                end
                model_update(0, lft_spd);
                model_update(1, right_spd);
            end
        end
    end

    typedef struct {
        logic [11:0] l;
        logic [11:0] r;
        int          l1, l2, r1, r2;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [11:0] rnd_spd();
        case ($urandom_range(0, 5))
            0:       return 12'h800;
            1:       return 12'h7FF;
            2:       return 12'h000;
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic wait_periods(input int n);
        repeat (n * 2048) @(posedge clk);
        #2;
    endtask

    task automatic chk_last(input string name, input int l1, input int l2,
                            input int r1, input int r2);
        chk({name, "_lft1"}, last[0][0], l1);
        chk({name, "_lft2"}, last[0][1], l2);
        chk({name, "_rght1"}, last[1][0], r1);
        chk({name, "_rght2"}, last[1][1], r2);
    endtask

    initial begin
        vecs[0] = '{l: 12'h200, r: 12'hE00, l1: 512,  l2: 0,    r1: 0,    r2: 512};
        vecs[1] = '{l: 12'h800, r: 12'h7FF, l1: 0,    l2: 2047, r1: 2047, r2: 0};
        vecs[2] = '{l: 12'h000, r: 12'h000, l1: 0,    l2: 0,    r1: 0,    r2: 0};
        vecs[3] = '{l: 12'h001, r: 12'hFFF, l1: 1,    l2: 0,    r1: 0,    r2: 1};
        vecs[4] = '{l: 12'hC00, r: 12'h123, l1: 0,    l2: 1024, r1: 291,  r2: 0};
        vecs[5] = '{l: 12'h400, r: 12'h000, l1: 1024, l2: 0,    r1: 0,    r2: 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_lft1", int'(lftPWM1), 0);
        chk("reset_lft2", int'(lftPWM2), 0);
        chk("reset_rght1", int'(rghtPWM1), 0);
        chk("reset_rght2", int'(rghtPWM2), 0);
        chk("reset_tick", int'(period_tick), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;  // counter sits at 0 from here until the next edge

`ifdef MTR_SLEW_LIMIT_EN
        lft_spd = 12'h100;
        wait_periods(1);
        for (int k = 1; k <= 4; k++) begin
            wait_periods(1);
            chk($sformatf("slew_step%0d", k), last[0][0], 64 * k);
        end
`else
        for (int i = 0; i < 6; i++) begin
            lft_spd   = vecs[i].l;
            right_spd = vecs[i].r;
            wait_periods(3);
            chk_last($sformatf("vec%0d", i), vecs[i].l1, vecs[i].l2, vecs[i].r1, vecs[i].r2);
        end

        // Mid-period reset while the left forward output is high (duty 1024).
        repeat (300) @(posedge clk);
        #2;
        chk("pre_reset_lft1", int'(lftPWM1), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_lft1", int'(lftPWM1), 0);
        chk("mid_reset_lft2", int'(lftPWM2), 0);
        chk("mid_reset_rght1", int'(rghtPWM1), 0);
        chk("mid_reset_rght2", int'(rghtPWM2), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_periods(1);
        chk("post_reset_duty0", last[0][0], 0);
        wait_periods(1);
        chk("post_reset_duty1024", last[0][0], 1024);

        // Reversal requested mid-period at cnt=1000.
        lft_spd   = 12'h200;
        right_spd = 12'h000;
        wait_periods(2);
        chk_last("rev_setup", 512, 0, 0, 0);
        repeat (1000) @(posedge clk);
        #2;
        lft_spd = 12'hE00;
        repeat (1048) @(posedge clk);
        #2;
        chk_last("rev_current", 512, 0, 0, 0);
        wait_periods(1);
        chk_last("rev_dead", 0, 0, 0, 0);
        wait_periods(1);
        chk_last("rev_new", 0, 512, 0, 0);

        // Random commands changed at random points; the model checks each period.
        for (int p = 0; p < 10; p++) begin
            int k;
            k = $urandom_range(1, 2040);
            repeat (k) @(posedge clk);
            #2;
            if ($urandom_range(0, 3) != 0) lft_spd = rnd_spd();
            if ($urandom_range(0, 3) != 0) right_spd = rnd_spd();
            repeat (2048 - k) @(posedge clk);
            #2;
        end
        wait_periods(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
